// File: rtl/sr04_if.sv
// Trig/echo bundle between an SR04 controller (master) and a sensor or its emulator (slave).
interface sr04_if;
  logic       trig;
  logic [8:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;
  logic       meas_done;

  modport master (
    output trig, distance_cm,
    input  echo, busy, trig_err, meas_done
  );

  modport slave (
    input  trig, distance_cm,
    output echo, busy, trig_err, meas_done
  );
endinterface

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 responder model: qualifies the trig pulse, waits a fixed burst delay, then drives an
// echo pulse whose width encodes the distance captured at trig fall. All outputs are registered.
module sr04_echo_emulator #(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned MIN_TRIG_US   = 10,
  parameter int unsigned ECHO_DELAY_US = 200,
  parameter int unsigned US_PER_CM     = 58,
  parameter int unsigned DIST_MAX      = 400,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 100
) (
  input  logic   clk,
  input  logic   rst,
  sr04_if.slave  bus
);

  localparam int unsigned CPU      = CLK_FREQ / 1_000_000;
  localparam logic [31:0] MIN_C    = 32'(MIN_TRIG_US * CPU);
  localparam logic [31:0] DLY_LAST = 32'(ECHO_DELAY_US * CPU - 1);
  localparam logic [31:0] HO_LAST  = 32'(HOLDOFF_US * CPU - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_DELAY, S_ECHO, S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] width_q, width_d;
  logic        trig_q, trig_d;
  logic        arm_q, arm_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        trig_err_q, trig_err_d;
  logic        meas_done_q, meas_done_d;

  logic        trig_rise, trig_fall, in_range;
  logic [31:0] dist_ext, echo_last;
  logic [15:0] width_calc;

  // arm_q blocks a trig that was already high out of reset from counting as a rising edge
  assign trig_d    = bus.trig;
  assign arm_d     = arm_q | ~bus.trig;
  assign trig_rise = bus.trig & ~trig_q & arm_q;
  assign trig_fall = ~bus.trig & trig_q;

  assign dist_ext   = {23'd0, bus.distance_cm};
  assign in_range   = (dist_ext != 32'd0) && (dist_ext <= 32'(DIST_MAX));
  assign width_calc = in_range ? 16'(32'(US_PER_CM) * dist_ext) : 16'(TIMEOUT_US);
  assign echo_last  = {16'd0, width_q} * CPU - 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      trig_q      <= 1'b0;
      arm_q       <= ~bus.trig;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      meas_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      trig_q      <= trig_d;
      arm_q       <= arm_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      trig_err_q  <= trig_err_d;
      meas_done_q <= meas_done_d;
    end
  end

  // cnt is zeroed on every state entry except TRIG, which counts the rising-edge cycle as 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          state_d = S_TRIG;
          cnt_d   = 32'd1;
        end
      end
      S_TRIG: begin
        if (trig_fall) begin
          cnt_d = '0;
          if (cnt_q >= MIN_C) begin
            width_d = width_calc;
            state_d = S_DELAY;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DELAY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = S_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_ECHO: begin
        if (cnt_q == echo_last) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    echo_d      = (state_d == S_ECHO);
    busy_d      = (state_d != S_IDLE);
    trig_err_d  = (state_q == S_TRIG) && (state_d == S_IDLE);
    meas_done_d = (state_q == S_ECHO) && (state_d == S_HOLD);
  end

  assign bus.echo      = echo_q;
  assign bus.busy      = busy_q;
  assign bus.trig_err  = trig_err_q;
  assign bus.meas_done = meas_done_q;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Bench for sr04_echo_emulator with shrunk timing so full sequences run in a few hundred cycles.
`timescale 1ns/1ps
module tb_sr04_echo_emulator;

  localparam int CLK_FREQ      = 2_000_000;
  localparam int MIN_TRIG_US   = 5;
  localparam int ECHO_DELAY_US = 7;
  localparam int US_PER_CM     = 3;
  localparam int DIST_MAX      = 20;
  localparam int TIMEOUT_US    = 70;
  localparam int HOLDOFF_US    = 4;
  localparam int CPU           = CLK_FREQ / 1_000_000;
  localparam int MIN_C         = MIN_TRIG_US * CPU;
  localparam int D_C           = ECHO_DELAY_US * CPU;
  localparam int HO_C          = HOLDOFF_US * CPU;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sr04_if bus ();

  sr04_echo_emulator #(
    .CLK_FREQ(CLK_FREQ), .MIN_TRIG_US(MIN_TRIG_US), .ECHO_DELAY_US(ECHO_DELAY_US),
    .US_PER_CM(US_PER_CM), .DIST_MAX(DIST_MAX), .TIMEOUT_US(TIMEOUT_US),
    .HOLDOFF_US(HOLDOFF_US)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // cyc read at a falling edge is the number of the rising edge just before it
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   echo_r[$], echo_f[$], busy_r[$], busy_f[$], err_c[$], done_c[$];
  logic echo_p = 1'b0, busy_p = 1'b0;
  int   overlap = 0;

  always @(negedge clk) begin
    if (bus.echo === 1'b1 && echo_p === 1'b0) echo_r.push_back(cyc);
    if (bus.echo === 1'b0 && echo_p === 1'b1) echo_f.push_back(cyc);
    if (bus.busy === 1'b1 && busy_p === 1'b0) busy_r.push_back(cyc);
    if (bus.busy === 1'b0 && busy_p === 1'b1) busy_f.push_back(cyc);
    if (bus.trig_err === 1'b1) err_c.push_back(cyc);
    if (bus.meas_done === 1'b1) done_c.push_back(cyc);
    if (bus.trig_err === 1'b1 && bus.meas_done === 1'b1) overlap++;
    echo_p = bus.echo;
    busy_p = bus.busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_one(input string name, input int q[$], input int exp);
    chk({name, "_count"}, q.size(), 1);
    if (q.size() > 0) chk({name, "_cycle"}, q[0], exp);
  endtask

  task automatic clear_q();
    echo_r.delete(); echo_f.delete(); busy_r.delete();
    busy_f.delete(); err_c.delete(); done_c.delete();
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Reference: echo width in cycles from the distance rules alone
  function automatic int model_width(input int d);
    if (d >= 1 && d <= DIST_MAX) return US_PER_CM * d * CPU;
    return TIMEOUT_US * CPU;
  endfunction

  // Drives a trig pulse sampled high on exactly h rising edges; r/f are the rise and fall sample edges
  task automatic pulse(input int h, input int d, output int r, output int f);
    bus.distance_cm = 9'(d);
    @(negedge clk);
    bus.trig = 1'b1;
    r = cyc + 1;
    repeat (h) @(negedge clk);
    bus.trig = 1'b0;
    f = cyc + 1;
  endtask

  task automatic check_txn(input string tag, input int r, input int f, input bit acc, input int w);
    if (acc) begin
      wait_cyc(f + D_C + w + HO_C + 3);
      chk_one({tag, "/busy_rise"}, busy_r, r);
      chk_one({tag, "/echo_rise"}, echo_r, f + D_C);
      chk_one({tag, "/echo_fall"}, echo_f, f + D_C + w);
      chk_one({tag, "/meas_done"}, done_c, f + D_C + w);
      chk_one({tag, "/busy_fall"}, busy_f, f + D_C + w + HO_C);
      chk({tag, "/trig_err_count"}, err_c.size(), 0);
    end else begin
      wait_cyc(f + 3);
      chk_one({tag, "/busy_rise"}, busy_r, r);
      chk_one({tag, "/trig_err"}, err_c, f);
      chk_one({tag, "/busy_fall"}, busy_f, f);
      chk({tag, "/echo_count"}, echo_r.size(), 0);
      chk({tag, "/meas_done_count"}, done_c.size(), 0);
    end
  endtask

  typedef struct {
    int h;
    int d;
    bit acc;
    int w;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int r, f, e, h, d;
    vecs[0] = '{10, 17, 1'b1, 102};
    vecs[1] = '{ 9, 17, 1'b0,   0};
    vecs[2] = '{10,  0, 1'b1, 140};
    vecs[3] = '{11, 21, 1'b1, 140};
    vecs[4] = '{12, 20, 1'b1, 120};
    vecs[5] = '{25,  1, 1'b1,   6};
    vecs[6] = '{ 1,  5, 1'b0,   0};
    vecs[7] = '{10, 511, 1'b1, 140};

    bus.trig = 1'b1;
    bus.distance_cm = '0;
    repeat (3) @(negedge clk);
    chk("reset_echo", int'(bus.echo), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_trig_err", int'(bus.trig_err), 0);
    chk("reset_meas_done", int'(bus.meas_done), 0);

    // trig high across reset release must not start a measurement
    rst = 1'b0;
    clear_q();
    repeat (20) @(negedge clk);
    bus.trig = 1'b0;
    repeat (10) @(negedge clk);
    chk("stuck_trig_busy_rise", busy_r.size(), 0);
    chk("stuck_trig_err", err_c.size(), 0);

    for (int i = 0; i < 8; i++) begin
      clear_q();
      pulse(vecs[i].h, vecs[i].d, r, f);
      check_txn($sformatf("vec%0d", i), r, f, vecs[i].acc, vecs[i].w);
      repeat (3) @(negedge clk);
    end

    // distance changes after the latch are ignored
    clear_q();
    pulse(12, 17, r, f);
    wait_cyc(f + 5);
    bus.distance_cm = 9'd100;
    wait_cyc(f + D_C + 40);
    bus.distance_cm = 9'd3;
    check_txn("dist_change", r, f, 1'b1, 102);
    repeat (3) @(negedge clk);

    // trig pulses during ECHO and HOLDOFF are ignored
    clear_q();
    pulse(10, 17, r, f);
    wait_cyc(f + 30);
    bus.trig = 1'b1;
    wait_cyc(f + 45);
    bus.trig = 1'b0;
    wait_cyc(f + D_C + 102 + 2);
    bus.trig = 1'b1;
    wait_cyc(f + D_C + 102 + 5);
    bus.trig = 1'b0;
    check_txn("ignore_busy", r, f, 1'b1, 102);
    repeat (3) @(negedge clk);
    clear_q();
    pulse(10, 8, r, f);
    check_txn("after_ignore", r, f, 1'b1, model_width(8));
    repeat (3) @(negedge clk);

    // trig rising in HOLDOFF and still high at IDLE entry is not accepted
    clear_q();
    pulse(10, 1, r, f);
    e = f + D_C + 6;
    wait_cyc(e + 2);
    bus.trig = 1'b1;
    wait_cyc(e + 20);
    bus.trig = 1'b0;
    wait_cyc(e + 25);
    chk("held_trig_busy_rises", busy_r.size(), 1);
    chk_one("held_trig_busy_fall", busy_f, e + HO_C);
    chk("held_trig_err", err_c.size(), 0);
    chk("held_trig_echo_rises", echo_r.size(), 1);

    // one-cycle reset in the middle of ECHO
    clear_q();
    pulse(10, 17, r, f);
    wait_cyc(f + D_C + 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_echo", int'(bus.echo), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    wait_cyc(f + D_C + 102 + HO_C + 5);
    chk("midrst_meas_done", done_c.size(), 0);
    chk("midrst_echo_rises", echo_r.size(), 1);
    clear_q();
    pulse(10, 5, r, f);
    check_txn("after_rst", r, f, 1'b1, model_width(5));
    repeat (3) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      h = $urandom_range(MIN_C + 15, MIN_C - 4);
      if ($urandom_range(0, 4) == 0) d = $urandom_range(300, 511);
      else d = $urandom_range(0, 25);
      clear_q();
      pulse(h, d, r, f);
      check_txn($sformatf("rand%0d_h%0d_d%0d", i, h, d), r, f, h >= MIN_C, model_width(d));
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    chk("err_done_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
